rs_chipkill_encoder: RTL and testbench



---
 rtl/rs_chipkill_encoder.sv | 154 +++++++++++++++
 tb/tb_rs_chipkill_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_chipkill_encoder.sv
// rs_chipkill_encoder
//   Streaming (10,8) Reed-Solomon encoder over GF(2^8) (poly 0x11D, a = 0x02)
//   for a chipkill-style write path. Eight data symbols arrive serially; the
//   two check symbols are accumulated on the fly and the full 80-bit codeword
//   is presented on a valid/ready output.
//
//   Codeword layout: [79-8i:72-8i] = data symbol i, [15:8] = P0, [7:0] = P1
//     P0 = d0 ^ d1 ^ ... ^ d7
//     P1 = a^0*d0 ^ a^1*d1 ^ ... ^ a^7*d7
//
//   Optional feature macro: RS_ENC_ERR_INJECT_EN
//     Adds inj_en / inj_mask. When inj_en is high during the 8th input beat,
//     inj_mask is XORed into the registered codeword.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sym_valid  input symbol valid
//   sym_ready  encoder can accept a symbol (decoded from state)
//   sym_data   8-bit data symbol, first beat is symbol 0
//   cw_valid   codeword valid
//   cw_ready   downstream accepts codeword
//   cw_data    80-bit codeword
//   busy       partial codeword accepted or codeword pending
//   inj_en     (RS_ENC_ERR_INJECT_EN only) enable mask injection
//   inj_mask   (RS_ENC_ERR_INJECT_EN only) 80-bit error mask
//
// FSM states
//   state | meaning
//   ACCUM | accepting data symbols, accumulating P0/P1
//   OUT   | codeword held on cw_data until cw_ready handshake

module rs_chipkill_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [7:0]  sym_data,
  output logic        cw_valid,
  input  logic        cw_ready,
  output logic [79:0] cw_data,
  output logic        busy
`ifdef RS_ENC_ERR_INJECT_EN
  ,
  input  logic        inj_en,
  input  logic [79:0] inj_mask
`endif
);

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  p0_q, p1_q;
  logic [7:0]  p0_next, p1_next;
  logic [7:0]  slots_q [7];
  logic [79:0] cw_q;
  logic [79:0] cw_clean, cw_load;
  logic        busy_q;
  logic        beat, last_beat, out_fire;

  // Multiply by a (0x02) with reduction by 0x11D.
  function automatic logic [7:0] mul_a(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Constant multiplier a^k, k selected by the running symbol count.
  function automatic logic [7:0] mul_a_pow(input logic [7:0] x, input logic [2:0] k);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) < k) r = mul_a(r);
    end
    return r;
  endfunction

  assign beat      = sym_valid & sym_ready;
  assign last_beat = beat & (cnt_q == 3'd7);
  assign out_fire  = cw_valid & cw_ready;

  assign p0_next = p0_q ^ sym_data;
  assign p1_next = p1_q ^ mul_a_pow(sym_data, cnt_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (last_beat) state_d = OUT;
      OUT:   if (out_fire)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    sym_ready = (state_q == ACCUM);
    cw_valid  = (state_q == OUT);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (beat)          cnt_d = cnt_q + 3'd1;
    else if (out_fire) cnt_d = 3'd0;
  end

  // The 8th symbol and final parities bypass their registers so the
  // codeword can be captured in the same cycle as the last beat.
  always_comb begin
    cw_clean = '0;
    for (int i = 0; i < 7; i++) cw_clean[79-8*i -: 8] = slots_q[i];
    cw_clean[23:16] = sym_data;
    cw_clean[15:8]  = p0_next;
    cw_clean[7:0]   = p1_next;
  end

`ifdef RS_ENC_ERR_INJECT_EN
  assign cw_load = inj_en ? (cw_clean ^ inj_mask) : cw_clean;
`else
  assign cw_load = cw_clean;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      p0_q   <= 8'h00;
      p1_q   <= 8'h00;
      cw_q   <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < 7; i++) slots_q[i] <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != 3'd0) | (state_d == OUT);
      if (beat) begin
        p0_q <= p0_next;
        p1_q <= p1_next;
        if (cnt_q != 3'd7) slots_q[cnt_q] <= sym_data;
      end else if (out_fire) begin
        p0_q <= 8'h00;
        p1_q <= 8'h00;
      end
      if (last_beat) cw_q <= cw_load;
    end
  end

  assign cw_data = cw_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rs_chipkill_encoder.sv
module tb_rs_chipkill_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [7:0]  sym_data = 8'h00;
  logic        cw_valid;
  logic        cw_ready = 1'b0;
  logic [79:0] cw_data;
  logic        busy;
`ifdef RS_ENC_ERR_INJECT_EN
  logic        inj_en = 1'b0;
  logic [79:0] inj_mask = '0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  rs_chipkill_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .busy      (busy)
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    .inj_en    (inj_en),
    .inj_mask  (inj_mask)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // General GF(2^8) multiply, poly 0x11D.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] alpha_pow(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < k; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [79:0] encode(input logic [63:0] d);
    logic [7:0] p0, p1, s;
    p0 = 8'h00;
    p1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s  = d[63-8*i -: 8];
      p0 = p0 ^ s;
      p1 = p1 ^ gf_mul(alpha_pow(i), s);
    end
    return {d, p0, p1};
  endfunction

  // Both parity rows of H applied to a received codeword.
  function automatic logic synd_zero(input logic [79:0] c);
    logic [7:0] s0, s1, s;
    s0 = c[15:8];
    s1 = c[7:0];
    for (int i = 0; i < 8; i++) begin
      s  = c[79-8*i -: 8];
      s0 = s0 ^ s;
      s1 = s1 ^ gf_mul(alpha_pow(i), s);
    end
    return (s0 == 8'h00) && (s1 == 8'h00);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    sym_valid = 1'b0;
    cw_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    while (!sym_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_beat_timeout: sym_ready=%0b required 1", sym_ready);
    end
    sym_valid = 1'b1;
    sym_data = d;
    @(negedge clk);
    sym_valid = 1'b0;
    sym_data = 8'($urandom);
  endtask

  task automatic send_cw(input logic [63:0] d, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_beat(d[63-8*i -: 8]);
    end
  endtask

  task automatic recv_cw(output logic [79:0] cw, input int stall, input string name);
    int n;
    logic stable, rdy_low;
    n = 0;
    while (!cw_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (cw_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_cw_valid_timeout: cw_valid=%0b required 1", name, cw_valid);
    end
    cw = cw_data;
    stable = 1'b1;
    rdy_low = (sym_ready === 1'b0);
    repeat (stall) begin
      @(negedge clk);
      if (cw_data !== cw || cw_valid !== 1'b1) stable = 1'b0;
      if (sym_ready !== 1'b0) rdy_low = 1'b0;
    end
    tests_run++;
    if (!stable || !rdy_low) begin
      tests_failed++;
      $display("FAIL %s_hold: stable=%0b sym_ready_low=%0b required 1/1", name, stable, rdy_low);
    end
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    tests_run++;
    if (sym_ready !== 1'b1 || cw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_after_hs: sym_ready=%0b cw_valid=%0b required 1/0", name, sym_ready, cw_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (sym_ready !== 1'b1 || cw_valid !== 1'b0 || cw_data !== 80'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: sym_ready=%0b cw_valid=%0b cw_data=%h busy=%0b required 1/0/0/0",
               sym_ready, cw_valid, cw_data, busy);
    end
  endtask

  task automatic test_latency_zero();
    logic [79:0] cw;
    for (int i = 0; i < 7; i++) send_beat(8'h00);
    tests_run++;
    if (cw_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_last_beat: cw_valid=%0b busy=%0b required 0/1", cw_valid, busy);
    end
    send_beat(8'h00);
    tests_run++;
    if (cw_valid !== 1'b1 || sym_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency: cw_valid=%0b sym_ready=%0b required 1/0", cw_valid, sym_ready);
    end
    recv_cw(cw, 0, "zero");
    tests_run++;
    if (cw !== 80'h0) begin
      tests_failed++;
      $display("FAIL zero_cw: got %h required %h", cw, 80'h0);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] vd [4];
    logic [79:0] ve [4];
    logic [79:0] cw;
    vd[0] = 64'h0100_0000_0000_0000; ve[0] = 80'h0100_0000_0000_0000_0101;
    vd[1] = 64'h0000_0000_0000_0001; ve[1] = 80'h0000_0000_0000_0001_0180;
    vd[2] = 64'h0000_0000_0000_0002; ve[2] = 80'h0000_0000_0000_0002_021D;
    vd[3] = 64'h0102_0304_0506_0708; ve[3] = 80'h0102_0304_0506_0708_0810;
    for (int v = 0; v < 4; v++) begin
      send_cw(vd[v], 1);
      recv_cw(cw, 1, "vector");
      tests_run++;
      if (cw !== ve[v]) begin
        tests_failed++;
        $display("FAIL vector%0d: got %h required %h", v, cw, ve[v]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [79:0] cw;
    d = {$urandom, $urandom};
    send_cw(d, 3);
    recv_cw(cw, 5, "backpressure");
    tests_run++;
    if (cw !== encode(d)) begin
      tests_failed++;
      $display("FAIL backpressure_cw: got %h required %h", cw, encode(d));
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [79:0] cw;
    int bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom};
      send_cw(d, 2);
      recv_cw(cw, $urandom_range(0, 3), "random");
      tests_run++;
      if (cw !== encode(d) || !synd_zero(cw)) begin
        tests_failed++;
        if (bad < 5)
          $display("FAIL random%0d: got %h required %h", n, cw, encode(d));
        bad++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] d;
    logic [79:0] cw;
    logic extra;
    for (int i = 0; i < 4; i++) send_beat(8'hA5 + 8'(i));
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (busy !== 1'b0 || cw_valid !== 1'b0 || sym_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_async: busy=%0b cw_valid=%0b sym_ready=%0b required 0/0/1",
               busy, cw_valid, sym_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = 64'h1122_3344_5566_7788;
    send_cw(d, 0);
    recv_cw(cw, 0, "mid_reset");
    tests_run++;
    if (cw !== encode(d)) begin
      tests_failed++;
      $display("FAIL mid_reset_cw: got %h required %h", cw, encode(d));
    end
    extra = 1'b0;
    cw_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (cw_valid !== 1'b0) extra = 1'b1;
    end
    cw_ready = 1'b0;
    tests_run++;
    if (extra) begin
      tests_failed++;
      $display("FAIL mid_reset_extra: extra codeword seen=%0b required 0", extra);
    end
  endtask

`ifdef RS_ENC_ERR_INJECT_EN
  task automatic test_inject();
    logic [79:0] cw;
    for (int i = 0; i < 7; i++) send_beat(8'h00);
    inj_en = 1'b1;
    inj_mask = 80'hFF << 72;
    send_beat(8'h00);
    inj_en = 1'b0;
    inj_mask = '0;
    recv_cw(cw, 2, "inject");
    tests_run++;
    if (cw !== 80'hFF00_0000_0000_0000_0000) begin
      tests_failed++;
      $display("FAIL inject: got %h required %h", cw, 80'hFF00_0000_0000_0000_0000);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency_zero();
    test_vectors();
    test_backpressure();
    test_random();
    test_mid_reset();
`ifdef RS_ENC_ERR_INJECT_EN
    test_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
